// File: rtl/trap_controller_if.sv
// Trap redirect channel from the trap/CSR unit to the branch resolver.
interface trap_controller_if;
    logic        trap_enable;
    logic [31:0] trap_handler_addr;
    logic        xret_enable;
    logic [31:0] epc_value;

    // Producer: the trap controller.
    modport master (
        output trap_enable,
        output trap_handler_addr,
        output xret_enable,
        output epc_value
    );

    // Consumer: the branch resolver.
    modport slave (
        input trap_enable,
        input trap_handler_addr,
        input xret_enable,
        input epc_value
    );
endinterface

// File: rtl/trap_controller.sv
// Machine-mode trap/CSR unit: detects interrupts and exceptions at commit, produces
// same-cycle redirects, owns the M-mode trap CSRs and serves the CSR RMW port.
module trap_controller #(
    parameter logic [31:0] RESET_MTVEC = 32'h0000_0100,
    parameter int unsigned XLEN        = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            instr_valid,
    input  logic [XLEN-1:0] commit_pc,
    input  logic [5:0]      excep_vec,
    input  logic [XLEN-1:0] excep_tval,
    input  logic            mret,
    input  logic            irq_ext,
    input  logic            irq_timer,
    input  logic            irq_soft,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    trap_controller_if.master exc
);

    localparam logic [11:0] ADDR_MSTATUS  = 12'h300;
    localparam logic [11:0] ADDR_MIE      = 12'h304;
    localparam logic [11:0] ADDR_MTVEC    = 12'h305;
    localparam logic [11:0] ADDR_MSCRATCH = 12'h340;
    localparam logic [11:0] ADDR_MEPC     = 12'h341;
    localparam logic [11:0] ADDR_MCAUSE   = 12'h342;
    localparam logic [11:0] ADDR_MTVAL    = 12'h343;
    localparam logic [11:0] ADDR_MIP      = 12'h344;

    localparam logic [1:0] OP_WRITE = 2'b01;
    localparam logic [1:0] OP_SET   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [XLEN-1:0] CAUSE_IRQ_EXT   = 32'h8000_000B;
    localparam logic [XLEN-1:0] CAUSE_IRQ_SOFT  = 32'h8000_0003;
    localparam logic [XLEN-1:0] CAUSE_IRQ_TIMER = 32'h8000_0007;

    // CSR state. mie_q holds {MEIE, MTIE, MSIE}; mepc_q drops the two always-zero bits.
    logic              mstatus_mie_q,  mstatus_mie_d;
    logic              mstatus_mpie_q, mstatus_mpie_d;
    logic [2:0]        mie_q,          mie_d;
    logic [XLEN-1:0]   mtvec_q,        mtvec_d;
    logic [XLEN-1:0]   mscratch_q,     mscratch_d;
    logic [XLEN-1:2]   mepc_q,         mepc_d;
    logic [XLEN-1:0]   mcause_q,       mcause_d;
    logic [XLEN-1:0]   mtval_q,        mtval_d;

    logic [2:0]        irq_pend;
    logic              take_irq;
    logic              take_exc;
    logic              trap_take;
    logic              xret_take;
    logic              is_irq;
    logic [XLEN-1:0]   trap_cause;
    logic [XLEN-1:0]   trap_tval;
    logic [XLEN-1:0]   handler_addr;
    logic [XLEN-1:0]   mstatus_val;
    logic [XLEN-1:0]   mie_val;
    logic [XLEN-1:0]   mip_val;
    logic [XLEN-1:0]   rdata;
    logic [XLEN-1:0]   csr_new;
    logic              csr_we;

    // Low PC bits never reach mepc.
    logic unused_pc_bits;
    assign unused_pc_bits = ^commit_pc[1:0];

    // Interrupt lines are sampled live; nothing is latched.
    always_comb begin
        irq_pend  = {irq_ext & mie_q[2], irq_timer & mie_q[1], irq_soft & mie_q[0]};
        take_irq  = instr_valid && mstatus_mie_q && (irq_pend != 3'b000);
        take_exc  = instr_valid && (excep_vec != 6'b000000);
        // Reset forces the redirect outputs low even mid-cycle.
        trap_take = !rst && (take_irq || take_exc);
        xret_take = !rst && instr_valid && mret && !trap_take;
    end

    // Cause and tval selection: interrupts first, then exceptions in fixed priority.
    always_comb begin
        is_irq     = 1'b0;
        trap_cause = '0;
        trap_tval  = '0;
        if (take_irq) begin
            is_irq = 1'b1;
            if (irq_pend[2]) begin
                trap_cause = CAUSE_IRQ_EXT;
            end else if (irq_pend[0]) begin
                trap_cause = CAUSE_IRQ_SOFT;
            end else begin
                trap_cause = CAUSE_IRQ_TIMER;
            end
        end else if (excep_vec[0]) begin
            trap_cause = 32'd0;
            trap_tval  = excep_tval;
        end else if (excep_vec[1]) begin
            trap_cause = 32'd2;
            trap_tval  = excep_tval;
        end else if (excep_vec[2]) begin
            trap_cause = 32'd3;
        end else if (excep_vec[3]) begin
            trap_cause = 32'd11;
        end else if (excep_vec[5]) begin
            trap_cause = 32'd4;
            trap_tval  = excep_tval;
        end else if (excep_vec[4]) begin
            trap_cause = 32'd6;
            trap_tval  = excep_tval;
        end
    end

    // Handler target: vectored only for interrupts in mode 01; modes 10/11 act as direct.
    always_comb begin
        handler_addr = '0;
        if (trap_take) begin
            handler_addr = {mtvec_q[XLEN-1:2], 2'b00};
            if (mtvec_q[1:0] == 2'b01 && is_irq) begin
                handler_addr = {mtvec_q[XLEN-1:2], 2'b00} + {26'd0, trap_cause[3:0], 2'b00};
            end
        end
    end

    // CSR read mux and read-modify-write operand.
    always_comb begin
        mstatus_val     = '0;
        mstatus_val[3]  = mstatus_mie_q;
        mstatus_val[7]  = mstatus_mpie_q;
        mie_val         = '0;
        mie_val[11]     = mie_q[2];
        mie_val[7]      = mie_q[1];
        mie_val[3]      = mie_q[0];
        mip_val         = '0;
        mip_val[11]     = irq_ext;
        mip_val[7]      = irq_timer;
        mip_val[3]      = irq_soft;

        case (csr_addr)
            ADDR_MSTATUS:  rdata = mstatus_val;
            ADDR_MIE:      rdata = mie_val;
            ADDR_MTVEC:    rdata = mtvec_q;
            ADDR_MSCRATCH: rdata = mscratch_q;
            ADDR_MEPC:     rdata = {mepc_q, 2'b00};
            ADDR_MCAUSE:   rdata = mcause_q;
            ADDR_MTVAL:    rdata = mtval_q;
            ADDR_MIP:      rdata = mip_val;
            default:       rdata = '0;
        endcase

        case (csr_op)
            OP_WRITE: csr_new = csr_wdata;
            OP_SET:   csr_new = rdata | csr_wdata;
            OP_CLEAR: csr_new = rdata & ~csr_wdata;
            default:  csr_new = rdata;
        endcase

        // A trapping instruction never touches CSRs.
        csr_we = instr_valid && !trap_take && (csr_op != 2'b00);
    end

    // Next-state: trap entry, else MRET, with a same-cycle CSR write overriding MRET.
    always_comb begin
        mstatus_mie_d  = mstatus_mie_q;
        mstatus_mpie_d = mstatus_mpie_q;
        mie_d          = mie_q;
        mtvec_d        = mtvec_q;
        mscratch_d     = mscratch_q;
        mepc_d         = mepc_q;
        mcause_d       = mcause_q;
        mtval_d        = mtval_q;

        if (trap_take) begin
            mepc_d         = commit_pc[XLEN-1:2];
            mcause_d       = trap_cause;
            mtval_d        = trap_tval;
            mstatus_mpie_d = mstatus_mie_q;
            mstatus_mie_d  = 1'b0;
        end else begin
            if (xret_take) begin
                mstatus_mie_d  = mstatus_mpie_q;
                mstatus_mpie_d = 1'b1;
            end
            if (csr_we) begin
                case (csr_addr)
                    ADDR_MSTATUS: begin
                        mstatus_mie_d  = csr_new[3];
                        mstatus_mpie_d = csr_new[7];
                    end
                    ADDR_MIE:      mie_d      = {csr_new[11], csr_new[7], csr_new[3]};
                    ADDR_MTVEC:    mtvec_d    = csr_new;
                    ADDR_MSCRATCH: mscratch_d = csr_new;
                    ADDR_MEPC:     mepc_d     = csr_new[XLEN-1:2];
                    ADDR_MCAUSE:   mcause_d   = csr_new;
                    ADDR_MTVAL:    mtval_d    = csr_new;
                    default: ;
                endcase
            end
        end
    end

    // CSR state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mstatus_mie_q  <= 1'b0;
            mstatus_mpie_q <= 1'b0;
            mie_q          <= '0;
            mtvec_q        <= RESET_MTVEC;
            mscratch_q     <= '0;
            mepc_q         <= '0;
            mcause_q       <= '0;
            mtval_q        <= '0;
        end else begin
            mstatus_mie_q  <= mstatus_mie_d;
            mstatus_mpie_q <= mstatus_mpie_d;
            mie_q          <= mie_d;
            mtvec_q        <= mtvec_d;
            mscratch_q     <= mscratch_d;
            mepc_q         <= mepc_d;
            mcause_q       <= mcause_d;
            mtval_q        <= mtval_d;
        end
    end

    // Outputs.
    always_comb begin
        csr_rdata             = rdata;
        exc.trap_enable       = trap_take;
        exc.trap_handler_addr = handler_addr;
        exc.xret_enable       = xret_take;
        exc.epc_value         = {mepc_q, 2'b00};
    end

endmodule

// File: tb/tb_trap_controller.sv
// Directed vector bench for trap_controller: a cycle-by-cycle table with hand-computed
// expectations, followed by hand-written async-reset and mepc-then-MRET sequences.
module tb_trap_controller;

    logic        clk;
    logic        rst;
    logic        instr_valid;
    logic [31:0] commit_pc;
    logic [5:0]  excep_vec;
    logic [31:0] excep_tval;
    logic        mret;
    logic        irq_ext;
    logic        irq_timer;
    logic        irq_soft;
    logic [11:0] csr_addr;
    logic [1:0]  csr_op;
    logic [31:0] csr_wdata;
    logic [31:0] csr_rdata;

    trap_controller_if exc_if ();

    trap_controller #(
        .RESET_MTVEC(32'h0000_0100),
        .XLEN       (32)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .instr_valid(instr_valid),
        .commit_pc  (commit_pc),
        .excep_vec  (excep_vec),
        .excep_tval (excep_tval),
        .mret       (mret),
        .irq_ext    (irq_ext),
        .irq_timer  (irq_timer),
        .irq_soft   (irq_soft),
        .csr_addr   (csr_addr),
        .csr_op     (csr_op),
        .csr_wdata  (csr_wdata),
        .csr_rdata  (csr_rdata),
        .exc        (exc_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        iv;
        logic [31:0] pc;
        logic [5:0]  ev;
        logic [31:0] tval;
        logic        mr;
        logic [2:0]  irq;     // {ext, timer, soft}
        logic [11:0] addr;
        logic [1:0]  op;
        logic [31:0] wdata;
        logic [31:0] e_rdata;
        logic        e_te;
        logic [31:0] e_ha;
        logic        e_xr;
        logic [31:0] e_epc;
    } vec_t;

    vec_t vecs[$];
    int   applied;
    int   miscompares;

    // excep_vec bits: {ld_misalign, st_misalign, ecall, ebreak, illegal, fetch_misalign}
    localparam logic [5:0] EV_NONE  = 6'b000000;
    localparam logic [5:0] EV_ILL   = 6'b000010;
    localparam logic [5:0] EV_EBRK  = 6'b000100;
    localparam logic [5:0] EV_ECALL = 6'b001000;

    function automatic vec_t mk(input logic iv, input logic [31:0] pc, input logic [5:0] ev,
                                input logic [31:0] tval, input logic mr, input logic [2:0] irq,
                                input logic [11:0] addr, input logic [1:0] op,
                                input logic [31:0] wdata, input logic [31:0] e_rdata,
                                input logic e_te, input logic [31:0] e_ha, input logic e_xr,
                                input logic [31:0] e_epc);
        vec_t v;
        v.iv = iv; v.pc = pc; v.ev = ev; v.tval = tval; v.mr = mr; v.irq = irq;
        v.addr = addr; v.op = op; v.wdata = wdata; v.e_rdata = e_rdata; v.e_te = e_te;
        v.e_ha = e_ha; v.e_xr = e_xr; v.e_epc = e_epc;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        instr_valid = v.iv;
        commit_pc   = v.pc;
        excep_vec   = v.ev;
        excep_tval  = v.tval;
        mret        = v.mr;
        irq_ext     = v.irq[2];
        irq_timer   = v.irq[1];
        irq_soft    = v.irq[0];
        csr_addr    = v.addr;
        csr_op      = v.op;
        csr_wdata   = v.wdata;
    endtask

    task automatic idle(input logic [11:0] addr);
        drive(mk(1'b0, 32'h0, EV_NONE, 32'h0, 1'b0, 3'b000, addr, 2'b00, 32'h0,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
    endtask

    initial begin
        applied     = 0;
        miscompares = 0;
        rst         = 1'b1;
        idle(12'h305);

        //                iv  pc            ev        tval          mr  irq     addr    op     wdata          rdata         te  ha            xr  epc
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h305, 2'b00, 32'h0,       32'h100,      0, 32'h0,   0, 32'h0));
        vecs.push_back(mk(1, 32'h2004,   EV_ECALL, 32'h55,    0, 3'b000, 12'h305, 2'b00, 32'h0,       32'h100,      1, 32'h100, 0, 32'h0));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h341, 2'b00, 32'h0,       32'h2004,     0, 32'h0,   0, 32'h2004));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h342, 2'b00, 32'h0,       32'd11,       0, 32'h0,   0, 32'h2004));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h343, 2'b00, 32'h0,       32'h0,        0, 32'h0,   0, 32'h2004));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b00, 32'h0,       32'h0,        0, 32'h0,   0, 32'h2004));
        vecs.push_back(mk(1, 32'h2008,   EV_NONE,  32'h0,     0, 3'b000, 12'h305, 2'b01, 32'h401,     32'h100,      0, 32'h0,   0, 32'h2004));
        vecs.push_back(mk(1, 32'h200C,   EV_NONE,  32'h0,     0, 3'b000, 12'h304, 2'b10, 32'h80,      32'h0,        0, 32'h0,   0, 32'h2004));
        vecs.push_back(mk(1, 32'h2010,   EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b10, 32'h8,       32'h0,        0, 32'h0,   0, 32'h2004));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b010, 12'h344, 2'b00, 32'h0,       32'h80,       0, 32'h0,   0, 32'h2004));
        // 10: timer interrupt, vectored
        vecs.push_back(mk(1, 32'h3000,   EV_NONE,  32'h0,     0, 3'b010, 12'h300, 2'b00, 32'h0,       32'h8,        1, 32'h41C, 0, 32'h2004));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b010, 12'h342, 2'b00, 32'h0,       32'h80000007, 0, 32'h0,   0, 32'h3000));
        vecs.push_back(mk(1, 32'h3004,   EV_NONE,  32'h0,     0, 3'b010, 12'h300, 2'b00, 32'h0,       32'h80,       0, 32'h0,   0, 32'h3000));
        // 13: illegal + ld_misalign with a suppressed mscratch write
        vecs.push_back(mk(1, 32'h4002,   6'b100010, 32'hDEAD, 0, 3'b000, 12'h340, 2'b01, 32'h1234,    32'h0,        1, 32'h400, 0, 32'h3000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h340, 2'b00, 32'h0,       32'h0,        0, 32'h0,   0, 32'h4000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h342, 2'b00, 32'h0,       32'd2,        0, 32'h0,   0, 32'h4000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h343, 2'b00, 32'h0,       32'hDEAD,     0, 32'h0,   0, 32'h4000));
        vecs.push_back(mk(1, 32'h4004,   EV_NONE,  32'h0,     0, 3'b000, 12'h341, 2'b01, 32'h2007,    32'h4000,     0, 32'h0,   0, 32'h4000));
        vecs.push_back(mk(1, 32'h4008,   EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b10, 32'h80,      32'h0,        0, 32'h0,   0, 32'h2004));
        // 19: MRET
        vecs.push_back(mk(1, 32'h400C,   EV_NONE,  32'h0,     1, 3'b000, 12'h300, 2'b00, 32'h0,       32'h80,       0, 32'h0,   1, 32'h2004));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b00, 32'h0,       32'h88,       0, 32'h0,   0, 32'h2004));
        // 21: MRET with ebreak: trap wins
        vecs.push_back(mk(1, 32'h5000,   EV_EBRK,  32'h77,    1, 3'b000, 12'h300, 2'b00, 32'h0,       32'h88,       1, 32'h400, 0, 32'h2004));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h342, 2'b00, 32'h0,       32'd3,        0, 32'h0,   0, 32'h5000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h343, 2'b00, 32'h0,       32'h0,        0, 32'h0,   0, 32'h5000));
        // 24: MRET with mstatus write: write wins
        vecs.push_back(mk(1, 32'h5004,   EV_NONE,  32'h0,     1, 3'b000, 12'h300, 2'b01, 32'h0,       32'h80,       0, 32'h0,   1, 32'h5000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b00, 32'h0,       32'h0,        0, 32'h0,   0, 32'h5000));
        vecs.push_back(mk(1, 32'h5008,   EV_NONE,  32'h0,     0, 3'b000, 12'h304, 2'b01, 32'hFFFFFFFF, 32'h80,      0, 32'h0,   0, 32'h5000));
        vecs.push_back(mk(1, 32'h500C,   EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b10, 32'h8,       32'h0,        0, 32'h0,   0, 32'h5000));
        // 28: all irqs + illegal: ext wins over everything
        vecs.push_back(mk(1, 32'h6000,   EV_ILL,   32'h99,    0, 3'b111, 12'h304, 2'b00, 32'h0,       32'h888,      1, 32'h42C, 0, 32'h5000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h342, 2'b00, 32'h0,       32'h8000000B, 0, 32'h0,   0, 32'h6000));
        vecs.push_back(mk(1, 32'h6004,   EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b10, 32'h8,       32'h80,       0, 32'h0,   0, 32'h6000));
        // 31: soft beats timer
        vecs.push_back(mk(1, 32'h7000,   EV_NONE,  32'h0,     0, 3'b011, 12'h342, 2'b00, 32'h0,       32'h8000000B, 1, 32'h40C, 0, 32'h6000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h342, 2'b00, 32'h0,       32'h80000003, 0, 32'h0,   0, 32'h7000));
        vecs.push_back(mk(1, 32'h7004,   EV_NONE,  32'h0,     0, 3'b000, 12'h7C0, 2'b01, 32'hFFFF,    32'h0,        0, 32'h0,   0, 32'h7000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h7C0, 2'b00, 32'h0,       32'h0,        0, 32'h0,   0, 32'h7000));
        // 35: mtvec mode 11 behaves as direct
        vecs.push_back(mk(1, 32'h7008,   EV_NONE,  32'h0,     0, 3'b000, 12'h305, 2'b01, 32'h503,     32'h401,      0, 32'h0,   0, 32'h7000));
        vecs.push_back(mk(1, 32'h700C,   EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b10, 32'h8,       32'h80,       0, 32'h0,   0, 32'h7000));
        vecs.push_back(mk(1, 32'h8000,   EV_NONE,  32'h0,     0, 3'b100, 12'h305, 2'b00, 32'h0,       32'h503,      1, 32'h500, 0, 32'h7000));
        vecs.push_back(mk(1, 32'h8004,   EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b10, 32'h8,       32'h80,       0, 32'h0,   0, 32'h8000));
        // 39-40: irq raised without a commit, dropped before the next commit
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b100, 12'h344, 2'b00, 32'h0,       32'h800,      0, 32'h0,   0, 32'h8000));
        vecs.push_back(mk(1, 32'h8008,   EV_NONE,  32'h0,     0, 3'b000, 12'h300, 2'b00, 32'h0,       32'h88,       0, 32'h0,   0, 32'h8000));
        // 41: ld_misalign beats st_misalign
        vecs.push_back(mk(1, 32'h9000,   6'b110000, 32'hBEEF, 0, 3'b000, 12'h342, 2'b00, 32'h0,       32'h8000000B, 1, 32'h500, 0, 32'h8000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h342, 2'b00, 32'h0,       32'd4,        0, 32'h0,   0, 32'h9000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h343, 2'b00, 32'h0,       32'hBEEF,     0, 32'h0,   0, 32'h9000));
        vecs.push_back(mk(1, 32'h9004,   EV_NONE,  32'h0,     0, 3'b000, 12'h304, 2'b11, 32'h80,      32'h888,      0, 32'h0,   0, 32'h9000));
        vecs.push_back(mk(0, 32'h0,      EV_NONE,  32'h0,     0, 3'b000, 12'h304, 2'b00, 32'h0,       32'h808,      0, 32'h0,   0, 32'h9000));

        #12 rst = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            @(posedge clk);
            #1;
            drive(vecs[i]);
            @(negedge clk);
            applied++;
            chk($sformatf("v%0d csr_rdata", i), csr_rdata, vecs[i].e_rdata);
            chk($sformatf("v%0d trap_enable", i), {31'd0, exc_if.trap_enable}, {31'd0, vecs[i].e_te});
            chk($sformatf("v%0d trap_handler_addr", i), exc_if.trap_handler_addr, vecs[i].e_ha);
            chk($sformatf("v%0d xret_enable", i), {31'd0, exc_if.xret_enable}, {31'd0, vecs[i].e_xr});
            chk($sformatf("v%0d epc_value", i), exc_if.epc_value, vecs[i].e_epc);
        end

        // Asynchronous reset in the middle of a trapping cycle.
        @(posedge clk);
        #1;
        drive(mk(1, 32'hA000, EV_ECALL, 32'h0, 1'b0, 3'b000, 12'h305, 2'b00, 32'h0,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        @(negedge clk);
        applied++;
        chk("pre_rst trap_enable", {31'd0, exc_if.trap_enable}, 32'd1);
        chk("pre_rst trap_handler_addr", exc_if.trap_handler_addr, 32'h500);
        #2 rst = 1'b1;
        #1;
        applied++;
        chk("rst trap_enable", {31'd0, exc_if.trap_enable}, 32'd0);
        chk("rst trap_handler_addr", exc_if.trap_handler_addr, 32'h0);
        chk("rst xret_enable", {31'd0, exc_if.xret_enable}, 32'd0);
        chk("rst epc_value", exc_if.epc_value, 32'h0);
        chk("rst mtvec", csr_rdata, 32'h100);
        @(posedge clk);
        #1;
        idle(12'h342);
        rst = 1'b0;
        @(negedge clk);
        applied++;
        chk("post_rst mcause", csr_rdata, 32'h0);
        csr_addr = 12'h341;
        #1;
        chk("post_rst mepc", csr_rdata, 32'h0);

        // mepc write immediately followed by MRET uses the new value.
        @(posedge clk);
        #1;
        drive(mk(1, 32'hB000, EV_NONE, 32'h0, 1'b0, 3'b000, 12'h341, 2'b01, 32'h1238,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        @(posedge clk);
        #1;
        drive(mk(1, 32'hB004, EV_NONE, 32'h0, 1'b1, 3'b000, 12'h300, 2'b00, 32'h0,
                 32'h0, 1'b0, 32'h0, 1'b0, 32'h0));
        @(negedge clk);
        applied++;
        chk("mepc_mret xret_enable", {31'd0, exc_if.xret_enable}, 32'd1);
        chk("mepc_mret epc_value", exc_if.epc_value, 32'h1238);
        @(posedge clk);
        #1;
        idle(12'h300);
        @(negedge clk);
        applied++;
        chk("mepc_mret mstatus", csr_rdata, 32'h80);

        $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
        $finish;
    end

endmodule
